// File: rtl/game_pkg.sv
// Shared game constants: platform table, collision codes and arbiter state encoding.
// Platform 2 is the only on-screen ledge; the rest are parked where no sprite reaches.
package game_pkg;

  localparam int NUM_PLATFORMS = 4;
  localparam int COORD_W       = 10;
  localparam int IDX_W         = 4;

  typedef enum logic [1:0] {
    COLL_NONE = 2'b00,
    COLL_HEAD = 2'b01,
    COLL_LAND = 2'b10,
    COLL_SIDE = 2'b11
  } coll_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic [COORD_W-1:0] pw;
    logic [COORD_W-1:0] ph;
  } platform_t;

  function automatic platform_t platform_at(input logic [IDX_W-1:0] idx);
    platform_t p;
    case (idx)
      4'd0:    p = {10'd1000, 10'd1000, 10'd20, 10'd20};
      4'd1:    p = {10'd0,    10'd1010, 10'd10, 10'd10};
      4'd2:    p = {10'd100,  10'd600,  10'd200, 10'd20};
      4'd3:    p = {10'd1010, 10'd0,    10'd10, 10'd10};
      default: p = {10'd1000, 10'd1000, 10'd20, 10'd20};
    endcase
    return p;
  endfunction

  // Merge priority is LAND > HEAD > SIDE > NONE, which is not the numeric code order.
  function automatic logic [1:0] coll_rank(input coll_code_e c);
    logic [1:0] r;
    case (c)
      COLL_LAND: r = 2'd3;
      COLL_HEAD: r = 2'd2;
      COLL_SIDE: r = 2'd1;
      default:   r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic coll_code_e coll_merge(input coll_code_e a, input coll_code_e b);
    return (coll_rank(b) > coll_rank(a)) ? b : a;
  endfunction

endpackage

// File: rtl/coll_check_box.sv
// Combinational box-versus-platform contact test; one instance is time-shared by the scan.
module coll_check_box
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] pw,
  input  logic [COORD_W-1:0] ph,
  output coll_code_e         code
);

  logic [COORD_W:0] x_r, y_b, p_r, p_b;
  logic             degenerate;
  logic             hov;

  // 11-bit sums so edges near 1023 never wrap.
  assign x_r = {1'b0, x} + {1'b0, w};
  assign y_b = {1'b0, y} + {1'b0, h};
  assign p_r = {1'b0, px} + {1'b0, pw};
  assign p_b = {1'b0, py} + {1'b0, ph};

  // A zero-width or zero-height box touches nothing.
  assign degenerate = (w == '0) || (h == '0);
  assign hov = !degenerate && ({1'b0, x} < p_r) && (x_r > {1'b0, px});

  always_comb begin
    code = COLL_NONE;
    if (hov && (y_b == {1'b0, py})) begin
      code = COLL_LAND;
    end else if (hov && ({1'b0, y} == p_b)) begin
      code = COLL_HEAD;
    end else if (hov && ({1'b0, y} < p_b) && (y_b > {1'b0, py})) begin
      code = COLL_SIDE;
    end
  end

endmodule

// File: rtl/coll_arbiter.sv
// Two-requester round-robin collision service: latch one box, scan the platform table
// one entry per cycle, then pulse done and publish the merged code for that requester.
module coll_arbiter
  import game_pkg::*;
#(
  parameter int NUM_PLAT = NUM_PLATFORMS
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w0,
  input  logic [COORD_W-1:0] h0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] w1,
  input  logic [COORD_W-1:0] h1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [1:0]         res0,
  output logic [1:0]         res1,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);

  // Handshake: a requester holds reqN until the single-cycle gntN pulse; operands are
  // captured on that grant, and doneN later marks resN as freshly valid.
  arb_state_e         state;
  logic [IDX_W-1:0]   idx;
  coll_code_e         acc;
  logic               lat_id;
  logic               last_id;
  logic [COORD_W-1:0] lat_x, lat_y, lat_w, lat_h;

  logic               grant_id;
  logic [COORD_W-1:0] sel_x, sel_y, sel_w, sel_h;
  platform_t          cur_plat;
  coll_code_e         cur_code;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    grant_id = req1;
    if (req0 && req1) begin
      grant_id = ~last_id;
    end
    sel_x = grant_id ? x1 : x0;
    sel_y = grant_id ? y1 : y0;
    sel_w = grant_id ? w1 : w0;
    sel_h = grant_id ? h1 : h0;
  end

  assign cur_plat  = platform_at(idx);
  assign state_dbg = state;

  coll_check_box u_check (
    .x    (lat_x),
    .y    (lat_y),
    .w    (lat_w),
    .h    (lat_h),
    .px   (cur_plat.px),
    .py   (cur_plat.py),
    .pw   (cur_plat.pw),
    .ph   (cur_plat.ph),
    .code (cur_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= COLL_NONE;
      lat_id  <= 1'b0;
      last_id <= 1'b1;
      lat_x   <= '0;
      lat_y   <= '0;
      lat_w   <= '0;
      lat_h   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res0    <= 2'b00;
      res1    <= 2'b00;
      busy    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state   <= ST_SCAN;
            busy    <= 1'b1;
            lat_id  <= grant_id;
            last_id <= grant_id;
            lat_x   <= sel_x;
            lat_y   <= sel_y;
            lat_w   <= sel_w;
            lat_h   <= sel_h;
            acc     <= COLL_NONE;
            idx     <= '0;
            gnt0    <= ~grant_id;
            gnt1    <= grant_id;
          end
        end
        ST_SCAN: begin
          acc <= coll_merge(acc, cur_code);
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (lat_id) begin
            done1 <= 1'b1;
            res1  <= acc;
          end else begin
            done0 <= 1'b1;
            res0  <= acc;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coll_arbiter.sv
// Randomized bench for coll_arbiter: drivers push expected {id, code} at issue time,
// a negedge monitor pops and checks on every done pulse.
module tb_coll_arbiter;
  import game_pkg::*;

  localparam int NP = 4;
  localparam int W  = 3;

  logic       clk, rst;
  logic       req0, req1;
  logic [9:0] x0, y0, w0, h0, x1, y1, w1, h1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [1:0] res0, res1, state_dbg;

  coll_arbiter #(.NUM_PLAT(NP)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .w0(w0), .h0(h0),
    .x1(x1), .y1(y1), .w1(w1), .h1(h1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   res_m[2];
  bit           last_m;
  int           g_cyc[2];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d (cycle %0d)", name, act, cyc);
  endtask

  // Reference: apply the contact rules to every table entry, keep the highest-priority hit.
  function automatic logic [1:0] ref_code(input int x, input int y, input int w, input int h);
    int best = 0;
    for (int p = 0; p < NP; p++) begin
      platform_t pl;
      int px, py, pw, ph, r;
      bit hov;
      pl = platform_at(4'(p));
      px = int'(pl.px); py = int'(pl.py); pw = int'(pl.pw); ph = int'(pl.ph);
      hov = (w != 0) && (h != 0) && (x < px + pw) && (x + w > px);
      r = 0;
      if (hov && (y + h == py)) r = 3;
      else if (hov && (y == py + ph)) r = 2;
      else if (hov && (y < py + ph) && (y + h > py)) r = 1;
      if (r > best) best = r;
    end
    case (best)
      3: return 2'b10;
      2: return 2'b01;
      1: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [W-1:0] e;
      int id;
      if (gnt0 && gnt1) fail_now("gnt_onehot", 3);
      if (gnt0) g_cyc[0] = cyc;
      if (gnt1) g_cyc[1] = cyc;
      if (done0 && done1) begin
        fail_now("done_onehot", 3);
      end else if (done0 || done1) begin
        id = done1 ? 1 : 0;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done", id);
        end else begin
          e = exp_q.pop_front();
          check("done_id", id, int'(e[2]));
          check("res", int'(id == 1 ? res1 : res0), int'(e[1:0]));
          check("latency", cyc - g_cyc[id], NP + 1);
          check("other_res", int'(id == 1 ? res0 : res1), int'(res_m[1-id]));
          res_m[id] = e[1:0];
        end
      end else begin
        check("res0_hold", int'(res0), int'(res_m[0]));
        check("res1_hold", int'(res1), int'(res_m[1]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_box(input int id, input int x, input int y, input int w, input int h);
    if (id == 1) begin
      x1 = 10'(x); y1 = 10'(y); w1 = 10'(w); h1 = 10'(h);
    end else begin
      x0 = 10'(x); y0 = 10'(y); w0 = 10'(w); h0 = 10'(h);
    end
  endtask

  task automatic set_req(input int id, input logic v);
    if (id == 1) req1 = v;
    else req0 = v;
  endtask

  task automatic scramble(input int id);
    drive_box(id, $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  task automatic push_exp(input int id);
    int x, y, w, h;
    if (id == 1) begin x = x1; y = y1; w = w1; h = h1; end
    else begin x = x0; y = y0; w = w0; h = h0; end
    exp_q.push_back({1'(id), ref_code(x, y, w, h)});
  endtask

  task automatic wait_gnt(output int who, output int at);
    who = -1;
    at  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        at  = cyc;
        break;
      end
    end
  endtask

  // Operands must already be on x/y/w/h for each requester in mask.
  task automatic run_round(input logic [1:0] mask);
    int order[$];
    int who, at, prev_at;
    @(posedge clk); #1;
    if (mask == 2'b11) begin
      order.push_back(last_m ? 0 : 1);
      order.push_back(last_m ? 1 : 0);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    foreach (order[k]) begin
      set_req(order[k], 1'b1);
      push_exp(order[k]);
    end
    prev_at = 0;
    foreach (order[k]) begin
      wait_gnt(who, at);
      if (who < 0) begin
        fail_now("gnt_timeout", order[k]);
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      check("gnt_id", who, order[k]);
      if (k > 0) check("gnt_spacing", at - prev_at, NP + 2);
      prev_at = at;
      last_m = who[0];
      @(posedge clk); #1;
      set_req(who, 1'b0);
      scramble(who);
    end
    repeat (NP + 3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    res_m[0] = 2'b00; res_m[1] = 2'b00;
    last_m = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_box(input int id);
    int x, y, w, h, mode;
    if ($urandom_range(0, 4) == 0) begin
      scramble(id);
      return;
    end
    x = $urandom_range(60, 320);
    w = $urandom_range(0, 60);
    h = $urandom_range(0, 64);
    mode = $urandom_range(0, 2);
    if (mode == 0) y = 600 - h;
    else if (mode == 1) y = 620;
    else y = $urandom_range(540, 640);
    drive_box(id, x, y, w, h);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int who, at, g1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    drive_box(0, 0, 0, 0, 0);
    drive_box(1, 0, 0, 0, 0);
    do_reset();

    @(negedge clk);
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_res0", int'(res0), 0);
    check("rst_res1", int'(res1), 0);
    check("rst_busy", int'(busy), 0);

    // Contention straight out of reset: 0, then 1, then 0 again.
    drive_box(0, 150, 536, 40, 64);
    drive_box(1, 150, 620, 40, 30);
    run_round(2'b11);
    drive_box(0, 90, 590, 20, 20);
    drive_box(1, 300, 590, 20, 20);
    run_round(2'b11);

    // Directed single requests: LAND, HEAD, SIDE, right-edge miss.
    drive_box(0, 150, 536, 40, 64);  run_round(2'b01);
    drive_box(1, 150, 620, 40, 30);  run_round(2'b10);
    drive_box(0, 90, 590, 20, 20);   run_round(2'b01);
    drive_box(0, 300, 590, 20, 20);  run_round(2'b01);
    drive_box(1, 150, 590, 0, 20);   run_round(2'b10);
    drive_box(0, 1010, 1013, 13, 10); run_round(2'b01);

    // A request raised and dropped while busy is never served.
    @(posedge clk); #1;
    drive_box(0, 150, 536, 40, 64);
    req0 = 1'b1;
    push_exp(0);
    wait_gnt(who, at);
    check("busy_case_gnt", who, 0);
    last_m = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1;
    g1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt1) g1++;
      if (k == 1) begin
        @(posedge clk); #1;
        req1 = 1'b0;
      end
    end
    check("no_gnt1_while_busy", g1, 0);

    // Reset two cycles into a scan aborts it; the next request is served right after.
    @(posedge clk); #1;
    drive_box(1, 150, 620, 40, 30);
    req1 = 1'b1;
    push_exp(1);
    wait_gnt(who, at);
    check("abort_case_gnt", who, 1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    res_m[0] = 2'b00; res_m[1] = 2'b00;
    last_m = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_box(0, 90, 590, 20, 20);
    req0 = 1'b1;
    push_exp(0);
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_res0", int'(res0), 0);
    check("abort_res1", int'(res1), 0);
    @(negedge clk);
    check("gnt_after_rst", int'(gnt0), 1);
    last_m = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b0;
    scramble(0);
    repeat (NP + 4) @(posedge clk);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      if (mask[0]) rand_box(0);
      if (mask[1]) rand_box(1);
      run_round(mask);
    end

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
